// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the 6-stage CPU:
// widths, forward select codes, load-use FSM and RF/EX bundle.
package cpu_pipe_pkg;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int OPW = 4;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_EM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_INTERLOCK = 1'b1
  } lu_state_e;

  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] opcode;
    logic [AW-1:0]  dest;
    logic           wb;
    logic           mem_rd;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
  } rf_ex_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// 4:1 operand select between register file and
// the three forwarding sources.
module operand_fwd_mux
  import cpu_pipe_pkg::*;
(
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rf_data,
  input  logic [DW-1:0] ex_data,
  input  logic [DW-1:0] em_data,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  always_comb begin
    data = rf_data;
    unique case (sel)
      FWD_RF: data = rf_data;
      FWD_EX: data = ex_data;
      FWD_EM: data = em_data;
      FWD_WB: data = wb_data;
    endcase
  end

endmodule

// File: rtl/rf_ex_operand_stage.sv
// RF->EX stage: operand forwarding, load-use
// interlock, stall/flush and the RF/EX register.
module rf_ex_operand_stage
  import cpu_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rf_valid,
  input  logic [OPW-1:0] rf_opcode,
  input  logic [AW-1:0]  rf_dest,
  input  logic [AW-1:0]  rf_src1,
  input  logic [AW-1:0]  rf_src2,
  input  logic           rf_use1,
  input  logic           rf_use2,
  input  logic           rf_use_imm,
  input  logic [DW-1:0]  rf_imm,
  input  logic           rf_wb,
  input  logic           rf_mem_rd,
  input  logic [DW-1:0]  rf_data_a,
  input  logic [DW-1:0]  rf_data_b,
  input  logic [1:0]     fwd_sel_a,
  input  logic [1:0]     fwd_sel_b,
  input  logic [DW-1:0]  fwd_ex_data,
  input  logic [DW-1:0]  fwd_em_data,
  input  logic [DW-1:0]  fwd_wb_data,
  input  logic [AW-1:0]  em_dest,
  input  logic           em_wb,
  input  logic           em_mem_rd,
  input  logic           stall_in,
  input  logic           flush,
  output logic           ex_valid,
  output logic [OPW-1:0] ex_opcode,
  output logic [AW-1:0]  ex_dest,
  output logic           ex_wb,
  output logic           ex_mem_rd,
  output logic [DW-1:0]  ex_op_a,
  output logic [DW-1:0]  ex_op_b,
  output logic           stall_up
);

  rf_ex_t    ex_q;
  rf_ex_t    cap;
  lu_state_e state;
  logic [1:0] bub_cnt;

  logic [DW-1:0] mux_a;
  logic [DW-1:0] mux_b;
  logic [DW-1:0] op_b;
  logic m_ex;
  logic m_em;
  logic haz_ex;
  logic haz_em;
  logic bubble;

  operand_fwd_mux u_mux_a (
    .sel     (fwd_sel_a),
    .rf_data (rf_data_a),
    .ex_data (fwd_ex_data),
    .em_data (fwd_em_data),
    .wb_data (fwd_wb_data),
    .data    (mux_a)
  );

  operand_fwd_mux u_mux_b (
    .sel     (fwd_sel_b),
    .rf_data (rf_data_b),
    .ex_data (fwd_ex_data),
    .em_data (fwd_em_data),
    .wb_data (fwd_wb_data),
    .data    (mux_b)
  );

  assign op_b = rf_use_imm ? rf_imm : mux_b;

  assign m_ex = rf_valid &
    ((rf_use1 & (rf_src1 == ex_q.dest)) |
     (rf_use2 & (rf_src2 == ex_q.dest)));
  assign m_em = rf_valid &
    ((rf_use1 & (rf_src1 == em_dest)) |
     (rf_use2 & (rf_src2 == em_dest)));

  // A load in EX needs two bubbles, a load in EX/M only one
  assign haz_ex = ex_q.valid & ex_q.mem_rd & ex_q.wb & m_ex;
  assign haz_em = em_mem_rd & em_wb & m_em;

  assign bubble = (state == ST_INTERLOCK) | haz_ex | haz_em;

  assign stall_up = rst_n &
    (haz_ex | haz_em | (state == ST_INTERLOCK) | stall_in);

  always_comb begin
    cap = '0;
    if (rf_valid) begin
      cap.valid  = 1'b1;
      cap.opcode = rf_opcode;
      cap.dest   = rf_dest;
      cap.wb     = rf_wb;
      cap.mem_rd = rf_mem_rd;
      cap.op_a   = mux_a;
      cap.op_b   = op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bub_cnt <= '0;
      ex_q    <= '0;
    end else if (flush) begin
      state   <= ST_IDLE;
      bub_cnt <= '0;
      ex_q    <= '0;
    end else if (!stall_in) begin
      unique case (state)
        ST_IDLE: begin
          if (haz_ex) begin
            state   <= ST_INTERLOCK;
            bub_cnt <= 2'd1;
          end
        end
        ST_INTERLOCK: begin
          if (bub_cnt <= 2'd1) begin
            state   <= ST_IDLE;
            bub_cnt <= '0;
          end else begin
            bub_cnt <= bub_cnt - 2'd1;
          end
        end
      endcase
      ex_q <= bubble ? '0 : cap;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_opcode = ex_q.opcode;
  assign ex_dest   = ex_q.dest;
  assign ex_wb     = ex_q.wb;
  assign ex_mem_rd = ex_q.mem_rd;
  assign ex_op_a   = ex_q.op_a;
  assign ex_op_b   = ex_q.op_b;

endmodule

// File: tb/tb_rf_ex_operand_stage.sv
// Bench for rf_ex_operand_stage: vector table,
// directed interlock sequences, random vs model.
module tb_rf_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_valid;
  logic [3:0]  rf_opcode;
  logic [2:0]  rf_dest;
  logic [2:0]  rf_src1;
  logic [2:0]  rf_src2;
  logic        rf_use1;
  logic        rf_use2;
  logic        rf_use_imm;
  logic [15:0] rf_imm;
  logic        rf_wb;
  logic        rf_mem_rd;
  logic [15:0] rf_data_a;
  logic [15:0] rf_data_b;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic [15:0] fwd_ex_data;
  logic [15:0] fwd_em_data;
  logic [15:0] fwd_wb_data;
  logic [2:0]  em_dest;
  logic        em_wb;
  logic        em_mem_rd;
  logic        stall_in;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_dest;
  logic        ex_wb;
  logic        ex_mem_rd;
  logic [15:0] ex_op_a;
  logic [15:0] ex_op_b;
  logic        stall_up;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_ex_operand_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rf_valid    (rf_valid),
    .rf_opcode   (rf_opcode),
    .rf_dest     (rf_dest),
    .rf_src1     (rf_src1),
    .rf_src2     (rf_src2),
    .rf_use1     (rf_use1),
    .rf_use2     (rf_use2),
    .rf_use_imm  (rf_use_imm),
    .rf_imm      (rf_imm),
    .rf_wb       (rf_wb),
    .rf_mem_rd   (rf_mem_rd),
    .rf_data_a   (rf_data_a),
    .rf_data_b   (rf_data_b),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .fwd_ex_data (fwd_ex_data),
    .fwd_em_data (fwd_em_data),
    .fwd_wb_data (fwd_wb_data),
    .em_dest     (em_dest),
    .em_wb       (em_wb),
    .em_mem_rd   (em_mem_rd),
    .stall_in    (stall_in),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_dest     (ex_dest),
    .ex_wb       (ex_wb),
    .ex_mem_rd   (ex_mem_rd),
    .ex_op_a     (ex_op_a),
    .ex_op_b     (ex_op_b),
    .stall_up    (stall_up)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        ui;
    logic [15:0] imm;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t vt[6];

  // reference model state: expected RF/EX contents plus owed bubbles
  logic        mv, mw, mr;
  logic [3:0]  mo;
  logic [2:0]  md;
  logic [15:0] ma, mb;
  int          pend;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] ex_bus();
    return {ex_valid, ex_opcode, ex_dest, ex_wb, ex_mem_rd,
            ex_op_a, ex_op_b};
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] sel,
                                       input logic [15:0] rfv);
    logic [15:0] s[4];
    s[0] = rfv;
    s[1] = fwd_ex_data;
    s[2] = fwd_em_data;
    s[3] = fwd_wb_data;
    return s[sel];
  endfunction

  function automatic bit reads(input logic [2:0] r);
    return rf_valid && ((rf_use1 && rf_src1 == r) ||
                        (rf_use2 && rf_src2 == r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rf_valid = 0; rf_opcode = 0; rf_dest = 0;
    rf_src1 = 0; rf_src2 = 0; rf_use1 = 0; rf_use2 = 0;
    rf_use_imm = 0; rf_imm = 0; rf_wb = 0; rf_mem_rd = 0;
    rf_data_a = 0; rf_data_b = 0;
    fwd_sel_a = 0; fwd_sel_b = 0;
    fwd_ex_data = 0; fwd_em_data = 0; fwd_wb_data = 0;
    em_dest = 0; em_wb = 0; em_mem_rd = 0;
    stall_in = 0; flush = 0;
  endtask

  // put a load (or plain op) writing dst into EX
  task automatic put_ex(input logic [2:0] dst, input logic ld);
    clear_in();
    rf_valid = 1; rf_opcode = 4'h2; rf_dest = dst;
    rf_wb = 1; rf_mem_rd = ld;
    tick();
    clear_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 2'b10, 2'b00, 1'b0, 16'h0000, 16'h1234, 16'h0B0B};
    vt[1] = '{1'b1, 2'b00, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h1111};
    vt[2] = '{1'b1, 2'b01, 2'b11, 1'b0, 16'h0000, 16'h1111, 16'h3333};
    vt[3] = '{1'b1, 2'b11, 2'b10, 1'b1, 16'hFFF0, 16'h3333, 16'hFFF0};
    vt[4] = '{1'b1, 2'b00, 2'b10, 1'b0, 16'h0000, 16'h0000, 16'h1234};
    vt[5] = '{1'b0, 2'b11, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000};

    clear_in();
    rst_n = 0;
    stall_in = 1;
    #1;
    chk("reset stall_up", 64'(stall_up), 64'd0);
    tick(); tick();
    chk("reset ex bus", 64'(ex_bus()), 64'd0);
    rst_n = 1;
    clear_in();

    // operand selection table, no hazards in play
    for (int i = 0; i < 6; i++) begin
      clear_in();
      rf_data_a = 16'h0000; rf_data_b = 16'h0B0B;
      fwd_ex_data = 16'h1111; fwd_em_data = 16'h1234;
      fwd_wb_data = 16'h3333;
      rf_valid = vt[i].v; rf_opcode = 4'(i); rf_dest = 3'(i);
      rf_wb = 1; fwd_sel_a = vt[i].sa; fwd_sel_b = vt[i].sb;
      rf_use_imm = vt[i].ui; rf_imm = vt[i].imm;
      #1;
      chk($sformatf("vec%0d stall_up", i), 64'(stall_up), 64'd0);
      tick();
      chk($sformatf("vec%0d op_a", i), 64'(ex_op_a), 64'(vt[i].ea));
      chk($sformatf("vec%0d op_b", i), 64'(ex_op_b), 64'(vt[i].eb));
      chk($sformatf("vec%0d valid/wb", i), 64'({ex_valid, ex_wb}),
          64'({vt[i].v, vt[i].v}));
    end

    // async reset while EX holds a valid instruction
    put_ex(3'd6, 1'b0);
    chk("pre-reset valid", 64'(ex_valid), 64'd1);
    #2;
    rst_n = 0;
    stall_in = 1;
    #1;
    chk("async reset ex bus", 64'(ex_bus()), 64'd0);
    chk("async reset stall_up", 64'(stall_up), 64'd0);
    tick();
    rst_n = 1;
    clear_in();
    rf_valid = 1; rf_opcode = 4'h9; rf_dest = 3'd4;
    rf_data_a = 16'h00AA;
    tick();
    chk("post-reset capture", 64'({ex_valid, ex_opcode, ex_op_a}),
        64'({1'b1, 4'h9, 16'h00AA}));

    // load in EX followed by a dependent ADD: two bubbles
    put_ex(3'd3, 1'b1);
    rf_valid = 1; rf_opcode = 4'h1; rf_dest = 3'd1;
    rf_src1 = 3'd3; rf_use1 = 1; rf_wb = 1;
    #1;
    chk("ldex stall c1", 64'(stall_up), 64'd1);
    tick();
    chk("ldex bubble1", 64'(ex_valid), 64'd0);
    em_dest = 3'd3; em_wb = 1; em_mem_rd = 1;
    #1;
    chk("ldex stall c2", 64'(stall_up), 64'd1);
    tick();
    chk("ldex bubble2", 64'(ex_valid), 64'd0);
    em_wb = 0; em_mem_rd = 0;
    fwd_sel_a = 2'b11; fwd_wb_data = 16'hBEEF;
    #1;
    chk("ldex stall c3", 64'(stall_up), 64'd0);
    tick();
    chk("ldex issue", 64'({ex_valid, ex_opcode, ex_op_a}),
        64'({1'b1, 4'h1, 16'hBEEF}));

    // load in EX/M: immediate form does not depend on src2
    clear_in();
    em_dest = 3'd2; em_wb = 1; em_mem_rd = 1;
    rf_valid = 1; rf_opcode = 4'h4; rf_dest = 3'd5; rf_wb = 1;
    rf_src2 = 3'd2; rf_use_imm = 1; rf_imm = 16'h0042;
    #1;
    chk("ldem imm stall", 64'(stall_up), 64'd0);
    tick();
    chk("ldem imm issue", 64'({ex_valid, ex_op_b}),
        64'({1'b1, 16'h0042}));
    rf_use_imm = 0; rf_use2 = 1; rf_data_b = 16'h7777;
    #1;
    chk("ldem use2 stall", 64'(stall_up), 64'd1);
    tick();
    chk("ldem bubble", 64'(ex_valid), 64'd0);
    em_wb = 0; em_mem_rd = 0;
    fwd_sel_b = 2'b11; fwd_wb_data = 16'h2222;
    #1;
    chk("ldem stall after", 64'(stall_up), 64'd0);
    tick();
    chk("ldem issue", 64'({ex_valid, ex_op_b}),
        64'({1'b1, 16'h2222}));

    // stall_in during interlock freezes the remaining bubble count
    put_ex(3'd3, 1'b1);
    rf_valid = 1; rf_opcode = 4'h7; rf_dest = 3'd7;
    rf_src2 = 3'd3; rf_use2 = 1; rf_wb = 1;
    tick();
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("frz stall_up %0d", i), 64'(stall_up), 64'd1);
      tick();
      chk($sformatf("frz ex bus %0d", i), 64'(ex_bus()), 64'd0);
    end
    stall_in = 0;
    #1;
    chk("frz release stall", 64'(stall_up), 64'd1);
    tick();
    chk("frz last bubble", 64'(ex_valid), 64'd0);
    #1;
    chk("frz done stall", 64'(stall_up), 64'd0);
    tick();
    chk("frz issue", 64'({ex_valid, ex_opcode}), 64'({1'b1, 4'h7}));

    // flush beats stall_in and cancels the interlock
    put_ex(3'd3, 1'b1);
    rf_valid = 1; rf_opcode = 4'hA; rf_dest = 3'd1;
    rf_src1 = 3'd3; rf_use1 = 1; rf_wb = 1;
    tick();
    flush = 1; stall_in = 1;
    tick();
    chk("flush bubble", 64'(ex_valid), 64'd0);
    flush = 0; stall_in = 0;
    #1;
    chk("flush stall_up", 64'(stall_up), 64'd0);
    tick();
    chk("flush then issue", 64'({ex_valid, ex_opcode}),
        64'({1'b1, 4'hA}));

    // randomized traffic against the reference model
    clear_in();
    rst_n = 0;
    tick();
    rst_n = 1;
    {mv, mw, mr, mo, md, ma, mb} = '0;
    pend = 0;
    for (int n = 0; n < 400; n++) begin
      bit hx, he, es;
      rf_valid = ($urandom_range(0, 3) != 0);
      rf_opcode = 4'($urandom);
      rf_dest = 3'($urandom_range(0, 3));
      rf_src1 = 3'($urandom_range(0, 3));
      rf_src2 = 3'($urandom_range(0, 3));
      rf_use1 = 1'($urandom); rf_use2 = 1'($urandom);
      rf_use_imm = 1'($urandom); rf_imm = 16'($urandom);
      rf_wb = 1'($urandom); rf_mem_rd = ($urandom_range(0, 2) == 0);
      rf_data_a = 16'($urandom); rf_data_b = 16'($urandom);
      fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom);
      fwd_ex_data = 16'($urandom); fwd_em_data = 16'($urandom);
      fwd_wb_data = 16'($urandom);
      em_dest = 3'($urandom_range(0, 3));
      em_wb = 1'($urandom); em_mem_rd = 1'($urandom);
      stall_in = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hx = mv && mr && mw && reads(md);
      he = em_mem_rd && em_wb && reads(em_dest);
      es = hx || he || pend > 0 || stall_in;
      #1;
      chk("rnd stall_up", 64'(stall_up), 64'(es));
      if (flush) begin
        {mv, mw, mr, mo, md, ma, mb} = '0;
        pend = 0;
      end else if (!stall_in) begin
        if (pend > 0) begin
          {mv, mw, mr, mo, md, ma, mb} = '0;
          pend--;
        end else if (hx) begin
          {mv, mw, mr, mo, md, ma, mb} = '0;
          pend = 1;
        end else if (he || !rf_valid) begin
          {mv, mw, mr, mo, md, ma, mb} = '0;
        end else begin
          mv = 1; mw = rf_wb; mr = rf_mem_rd;
          mo = rf_opcode; md = rf_dest;
          ma = pick(fwd_sel_a, rf_data_a);
          mb = rf_use_imm ? rf_imm : pick(fwd_sel_b, rf_data_b);
        end
      end
      tick();
      chk("rnd ex bus", 64'(ex_bus()),
          64'({mv, mo, md, mw, mr, ma, mb}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
